// File: rtl/if_stage_bht.sv
// Instruction-fetch stage with IF/ID pipeline register and a 2-bit saturating-counter
// branch history table predicting conditional branches.
module if_stage_bht #(
    parameter logic [31:0] RESET_PC  = 32'h00003000,
    parameter int unsigned BHT_IDX_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Stall,
    input  logic        Flush,
    input  logic [31:0] Redirect_pc,
    input  logic        Upd_en,
    input  logic [31:0] Upd_pc,
    input  logic        Upd_taken,
    input  logic [31:0] IM_instr,
    output logic [31:0] IF_pc,
    output logic [31:0] ID_pc,
    output logic [31:0] ID_instr,
    output logic [31:0] ID_pcadd4,
    output logic        ID_pre
);

    localparam int unsigned DEPTH = 1 << BHT_IDX_W;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } ctr_t;

    ctr_t bht [DEPTH];

    logic [5:0]           opcode;
    logic                 cond;
    logic [BHT_IDX_W-1:0] idx;
    logic [BHT_IDX_W-1:0] uidx;
    logic                 pred;
    logic [31:0]          pc_add4;
    logic [31:0]          target;
    ctr_t                 ctr_next;

    // Only the index bits of Upd_pc and the opcode/offset fields of IM_instr matter here.
    logic unused_bits;
    assign unused_bits = ^{Upd_pc[31:BHT_IDX_W+2], Upd_pc[1:0], IM_instr[25:16]};

    always_comb begin
        opcode  = IM_instr[31:26];
        cond    = (opcode == 6'h04) || (opcode == 6'h05) || (opcode == 6'h06) ||
                  (opcode == 6'h07) || (opcode == 6'h01);
        idx     = IF_pc[BHT_IDX_W+1:2];
        uidx    = Upd_pc[BHT_IDX_W+1:2];
        pred    = cond && (bht[idx] == WEAK_T || bht[idx] == STRONG_T);
        pc_add4 = IF_pc + 32'd4;
        target  = pc_add4 + {{14{IM_instr[15]}}, IM_instr[15:0], 2'b00};
    end

    always_comb begin
        ctr_next = bht[uidx];
        case (bht[uidx])
            STRONG_NT: ctr_next = Upd_taken ? WEAK_NT  : STRONG_NT;
            WEAK_NT:   ctr_next = Upd_taken ? WEAK_T   : STRONG_NT;
            WEAK_T:    ctr_next = Upd_taken ? STRONG_T : WEAK_NT;
            STRONG_T:  ctr_next = Upd_taken ? STRONG_T : WEAK_T;
            default:   ctr_next = WEAK_NT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            IF_pc     <= RESET_PC;
            ID_pc     <= RESET_PC;
            ID_instr  <= '0;
            ID_pcadd4 <= RESET_PC;
            ID_pre    <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                bht[i[BHT_IDX_W-1:0]] <= WEAK_NT;
            end
        end else begin
            if (Flush) begin
                IF_pc     <= Redirect_pc;
                ID_pc     <= RESET_PC;
                ID_instr  <= '0;
                ID_pcadd4 <= RESET_PC;
                ID_pre    <= 1'b0;
            end else if (!Stall) begin
                IF_pc     <= pred ? target : pc_add4;
                ID_pc     <= IF_pc;
                ID_instr  <= IM_instr;
                ID_pcadd4 <= pc_add4;
                ID_pre    <= pred;
            end
            // Prediction above reads the pre-update counter; no same-cycle bypass.
            if (Upd_en) begin
                bht[uidx] <= ctr_next;
            end
        end
    end

endmodule
